tcp_hdr_parser: RTL and testbench
=================================

Name: tcp_hdr_parser

Overview:
- Byte-stream Ethernet/IPv4/TCP header parser that sits directly upstream of the connection-table searcher.
- Extracts the connection tuple from each received frame, drives the searcher request interface with the required setup timing, and waits for completion.
- Issues a follow-up delete request for FIN/RST segments that hit an existing connection.
- Hands the per-frame result (connection ID and status) to the downstream segment processor.

Parameters:
- SETUP_CYC, 2, cycles tuple outputs are held stable before hp_rq leaves 2'b00 (minimum 2).
- TIMEOUT_CYC, 255, cycles to wait for a searcher done edge before aborting.

Ports:
- hp_clk  in  1  clock
- hp_rst  in  1  reset; synchronous, active-high
- hp_in_data  in  8  frame byte
- hp_in_valid  in  1  byte valid
- hp_in_sof  in  1  first byte of frame (qualified by valid)
- hp_in_eof  in  1  last byte of frame (qualified by valid)
- hp_in_ready  out  1  parser accepts byte
- hp_rq  out  2  searcher request: 00 none, 01 lookup/insert, 10 delete
- hp_id_out  out  8  connection ID for delete requests
- hp_mac_src, hp_mac_dst  out  24  low 24 bits (frame bytes 3-5 of each MAC field)
- hp_ip_src, hp_ip_dst  out  32  IPv4 addresses
- hp_port_src, hp_port_dst  out  16  TCP ports
- hp_rs_done  in  1  searcher done (level)
- hp_rs_error  in  8  searcher status (8'h01 existing, 8'h02 new)
- hp_rs_id  in  8  searcher returned ID
- hp_res_valid  out  1  result available
- hp_res_ready  in  1  downstream accepts result
- hp_res_id  out  8  connection ID
- hp_res_error  out  8  status; 8'hFF means timeout
- hp_res_del  out  1  connection was deleted
- hp_drop_cnt  out  16  dropped-frame counter, saturating

Behaviour:
- Reset values: all outputs 0, except hp_in_ready=1. State goes to IDLE; byte counter, timer, tuple registers and hp_drop_cnt clear.
- Reset mid-operation aborts any request in the same cycle; hp_rq reads 00 on the next edge.
- Byte offsets are counted from sof, with the sof byte at offset 0. A byte is accepted when hp_in_valid && hp_in_ready.
- Field offsets:
  - dst MAC: 0-5; src MAC: 6-11; ethertype: 12-13 (must be 16'h0800).
  - Byte 14: version must be 4; IHL in [5,15].
  - Protocol: byte 23 (must be 6).
  - IP src: 26-29; IP dst: 30-33.
  - T = 14 + 4*IHL. Src port: T..T+1; dst port: T+2..T+3; flags: T+13 (FIN bit0, RST bit2).
- Offset counter is 7 bits; the maximum used offset is 87.
- States:
  - IDLE: hp_in_ready=1. A byte with sof goes to HDR; bytes without sof are discarded.
  - HDR: capture fields. If a check fails, go to SKIP and increment drop. If eof arrives before offset T+13, go to IDLE and increment drop. After T+13: go to SETUP if that byte was eof, else go to SKIP_OK.
  - SKIP: consume bytes to eof, then go to IDLE.
  - SKIP_OK: consume bytes to eof, then go to SETUP.
  - A sof seen in HDR, SKIP or SKIP_OK restarts HDR at offset 0 and increments drop.
  - SETUP: hp_in_ready=0; tuple outputs stable; hp_rq=00 for SETUP_CYC cycles, then go to REQ.
  - REQ: hp_rq=01. On a done rising edge (hp_rs_done && !done_q), latch id and error and set hp_rq=00. If FIN|RST && error==8'h01, go to DSETUP; else go to RESULT.
  - DSETUP: hp_id_out=latched id; hp_rq=00 for SETUP_CYC cycles, then go to DREQ.
  - DREQ: hp_rq=10. On a done rising edge, set hp_res_del=1 and go to RESULT. If done is already high with no new edge, a re-assertion after a low is required; the parser waits.
  - RESULT: hp_res_valid=1; fields are held until hp_res_ready, then go to IDLE.
- Timeout: the timer runs in REQ and DREQ. At TIMEOUT_CYC: hp_rq=00, hp_res_error=8'hFF, go to RESULT.
- Done edge detection is mandatory because the searcher holds done high.
- hp_drop_cnt saturates at 16'hFFFF.
- Tuple outputs change only in HDR and are stable from SETUP through DREQ.

Test Plan:
- Valid SYN frame, IHL=5, searcher returns done with error 02 and id 8'h05 -> hp_rq=01 starting exactly 2 cycles after the last header byte; hp_res_id=05, hp_res_error=02, hp_res_del=0.
- FIN frame, searcher answers 01/id 8'h03 -> hp_rq=10 with hp_id_out=03 after 2 idle cycles; result shows del=1, id=03.
- Ethertype 0x86DD frame, then an IPv4 UDP (proto 17) frame -> no hp_rq activity; hp_drop_cnt=2.
- IHL=7 frame -> ports taken from offsets 42-43 and 44-45; frame truncated at offset 40 with eof -> drop, counter +1.
- Searcher never raises done, TIMEOUT_CYC=255 -> hp_rq returns to 00 at cycle 255; result error=FF.
- Reset asserted during REQ -> next cycle hp_rq=00, hp_in_ready=1, hp_res_valid=0; hp_res_ready held low in RESULT keeps result stable for 10 cycles.

Source files
------------

// File: rtl/tcp_hdr_parser_if.sv
// tcp_hdr_parser_if
//   Groups the byte-stream input, searcher request/response and result handshake of the
//   TCP header parser into one bundle.
//   master : parser side (drives hp_in_ready, hp_rq, tuple, id, result, drop counter)
//   slave  : environment side (drives stream bytes, searcher response, hp_res_ready)
interface tcp_hdr_parser_if;
   logic [7:0]  hp_in_data;
   logic        hp_in_valid;
   logic        hp_in_sof;
   logic        hp_in_eof;
   logic        hp_in_ready;
   logic [1:0]  hp_rq;
   logic [7:0]  hp_id_out;
   logic [23:0] hp_mac_src;
   logic [23:0] hp_mac_dst;
   logic [31:0] hp_ip_src;
   logic [31:0] hp_ip_dst;
   logic [15:0] hp_port_src;
   logic [15:0] hp_port_dst;
   logic        hp_rs_done;
   logic [7:0]  hp_rs_error;
   logic [7:0]  hp_rs_id;
   logic        hp_res_valid;
   logic        hp_res_ready;
   logic [7:0]  hp_res_id;
   logic [7:0]  hp_res_error;
   logic        hp_res_del;
   logic [15:0] hp_drop_cnt;

   modport master (
      input  hp_in_data, hp_in_valid, hp_in_sof, hp_in_eof,
      input  hp_rs_done, hp_rs_error, hp_rs_id, hp_res_ready,
      output hp_in_ready, hp_rq, hp_id_out, hp_mac_src, hp_mac_dst, hp_ip_src, hp_ip_dst,
      output hp_port_src, hp_port_dst, hp_res_valid, hp_res_id, hp_res_error, hp_res_del,
      output hp_drop_cnt
   );

   modport slave (
      output hp_in_data, hp_in_valid, hp_in_sof, hp_in_eof,
      output hp_rs_done, hp_rs_error, hp_rs_id, hp_res_ready,
      input  hp_in_ready, hp_rq, hp_id_out, hp_mac_src, hp_mac_dst, hp_ip_src, hp_ip_dst,
      input  hp_port_src, hp_port_dst, hp_res_valid, hp_res_id, hp_res_error, hp_res_del,
      input  hp_drop_cnt
   );
endinterface

// File: rtl/tcp_hdr_parser.sv
// tcp_hdr_parser
//   Parses Ethernet/IPv4/TCP headers from a byte stream, presents the connection tuple to the
//   connection-table searcher, issues lookup (and delete for FIN/RST hits) requests and hands
//   the per-frame result downstream.
//   hp_clk  : clock
//   hp_rst  : synchronous active-high reset
//   bus     : stream input, searcher request/response, result handshake, drop counter
module tcp_hdr_parser #(
   parameter int unsigned SETUP_CYC   = 2,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input logic              hp_clk,
   input logic              hp_rst,
   tcp_hdr_parser_if.master bus
);

   localparam logic [15:0] SetupMax = 16'(SETUP_CYC - 1);
   localparam logic [15:0] TmrMax   = 16'(TIMEOUT_CYC - 1);

   typedef enum logic [3:0] {
      StIdle, StHdr, StSkip, StSkipOk, StSetup, StReq, StDsetup, StDreq, StResult
   } state_e;

   state_e      r_state, w_state_nxt;
   logic [6:0]  r_off, r_t, w_off;
   logic [15:0] r_tmr, r_drop;
   logic        r_done_q, r_finrst, r_res_del;
   logic [23:0] r_mac_src, r_mac_dst;
   logic [31:0] r_ip_src, r_ip_dst;
   logic [15:0] r_port_src, r_port_dst;
   logic [7:0]  r_res_id, r_res_error, r_id_out;

   logic w_ready, w_acc, w_eof, w_hdr_byte, w_chk_fail, w_hdr_last, w_done_rise;
   logic w_drop_inc, w_tmr_inc, w_latch_rs, w_set_del, w_timeout, w_clr_res;
   logic [7:0] w_d;

   assign w_d         = bus.hp_in_data;
   assign w_ready     = (r_state == StIdle) || (r_state == StHdr) ||
                        (r_state == StSkip) || (r_state == StSkipOk);
   assign w_acc       = bus.hp_in_valid && w_ready;
   assign w_eof       = w_acc && bus.hp_in_eof;
   // A sof byte always parses as offset 0, whichever stream state it arrives in.
   assign w_off       = bus.hp_in_sof ? 7'd0 : r_off;
   assign w_hdr_byte  = w_acc && ((r_state == StHdr) || bus.hp_in_sof);
   assign w_chk_fail  = w_hdr_byte && (((w_off == 7'd12) && (w_d != 8'h08)) ||
                                       ((w_off == 7'd13) && (w_d != 8'h00)) ||
                                       ((w_off == 7'd14) && ((w_d[7:4] != 4'h4) ||
                                                             (w_d[3:0] < 4'h5))) ||
                                       ((w_off == 7'd23) && (w_d != 8'h06)));
   // r_t is only valid once offset 14 has passed; the >=47 guard keeps stale values out.
   assign w_hdr_last  = w_hdr_byte && (w_off >= 7'd47) && (w_off == r_t + 7'd13);
   assign w_done_rise = bus.hp_rs_done && !r_done_q;

   always_comb begin
      w_state_nxt = r_state;
      w_drop_inc  = 1'b0;
      w_tmr_inc   = 1'b0;
      w_latch_rs  = 1'b0;
      w_set_del   = 1'b0;
      w_timeout   = 1'b0;
      w_clr_res   = 1'b0;
      case (r_state)
         StIdle, StHdr, StSkip, StSkipOk: begin
            if (w_hdr_byte) begin
               if ((r_state != StIdle) && bus.hp_in_sof) w_drop_inc = 1'b1;
               if (w_chk_fail) begin
                  w_drop_inc  = 1'b1;
                  w_state_nxt = w_eof ? StIdle : StSkip;
               end else if (w_hdr_last) begin
                  w_state_nxt = w_eof ? StSetup : StSkipOk;
               end else if (w_eof) begin
                  w_drop_inc  = 1'b1;
                  w_state_nxt = StIdle;
               end else begin
                  w_state_nxt = StHdr;
               end
            end else if (w_eof) begin
               if (r_state == StSkip)   w_state_nxt = StIdle;
               if (r_state == StSkipOk) w_state_nxt = StSetup;
            end
         end
         StSetup, StDsetup: begin
            if (r_tmr == SetupMax) begin
               w_state_nxt = (r_state == StSetup) ? StReq : StDreq;
               w_clr_res   = (r_state == StSetup);
            end else begin
               w_tmr_inc = 1'b1;
            end
         end
         StReq, StDreq: begin
            if (w_done_rise) begin
               if (r_state == StReq) begin
                  w_latch_rs  = 1'b1;
                  w_state_nxt = (r_finrst && (bus.hp_rs_error == 8'h01)) ? StDsetup : StResult;
               end else begin
                  w_set_del   = 1'b1;
                  w_state_nxt = StResult;
               end
            end else if (r_tmr == TmrMax) begin
               w_timeout   = 1'b1;
               w_state_nxt = StResult;
            end else begin
               w_tmr_inc = 1'b1;
            end
         end
         StResult: if (bus.hp_res_ready) w_state_nxt = StIdle;
         default:  w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge hp_clk) begin
      if (hp_rst) begin
         r_state     <= StIdle;
         r_off       <= '0;
         r_t         <= '0;
         r_tmr       <= '0;
         r_drop      <= '0;
         r_done_q    <= 1'b0;
         r_finrst    <= 1'b0;
         r_mac_src   <= '0;
         r_mac_dst   <= '0;
         r_ip_src    <= '0;
         r_ip_dst    <= '0;
         r_port_src  <= '0;
         r_port_dst  <= '0;
         r_res_id    <= '0;
         r_res_error <= '0;
         r_res_del   <= 1'b0;
         r_id_out    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_done_q <= bus.hp_rs_done;
         r_tmr    <= w_tmr_inc ? r_tmr + 16'd1 : 16'd0;
         if (w_drop_inc && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
         if (w_hdr_byte) begin
            r_off <= w_off + 7'd1;
            case (w_off)
               7'd3:  r_mac_dst[23:16] <= w_d;
               7'd4:  r_mac_dst[15:8]  <= w_d;
               7'd5:  r_mac_dst[7:0]   <= w_d;
               7'd9:  r_mac_src[23:16] <= w_d;
               7'd10: r_mac_src[15:8]  <= w_d;
               7'd11: r_mac_src[7:0]   <= w_d;
               7'd14: r_t <= 7'd14 + {1'b0, w_d[3:0], 2'b00};
               7'd26: r_ip_src[31:24]  <= w_d;
               7'd27: r_ip_src[23:16]  <= w_d;
               7'd28: r_ip_src[15:8]   <= w_d;
               7'd29: r_ip_src[7:0]    <= w_d;
               7'd30: r_ip_dst[31:24]  <= w_d;
               7'd31: r_ip_dst[23:16]  <= w_d;
               7'd32: r_ip_dst[15:8]   <= w_d;
               7'd33: r_ip_dst[7:0]    <= w_d;
               default: ;
            endcase
            if (w_off >= 7'd34) begin
               if (w_off == r_t)          r_port_src[15:8] <= w_d;
               if (w_off == r_t + 7'd1)   r_port_src[7:0]  <= w_d;
               if (w_off == r_t + 7'd2)   r_port_dst[15:8] <= w_d;
               if (w_off == r_t + 7'd3)   r_port_dst[7:0]  <= w_d;
            end
            if (w_hdr_last) r_finrst <= w_d[0] | w_d[2];
         end
         if (w_clr_res) begin
            r_res_id    <= '0;
            r_res_error <= '0;
            r_res_del   <= 1'b0;
         end
         if (w_latch_rs) begin
            r_res_id    <= bus.hp_rs_id;
            r_res_error <= bus.hp_rs_error;
            r_id_out    <= bus.hp_rs_id;
         end
         if (w_timeout) r_res_error <= 8'hFF;
         if (w_set_del) r_res_del   <= 1'b1;
      end
   end

   assign bus.hp_in_ready  = w_ready;
   assign bus.hp_rq        = (r_state == StReq)  ? 2'b01 :
                             (r_state == StDreq) ? 2'b10 : 2'b00;
   assign bus.hp_id_out    = r_id_out;
   assign bus.hp_mac_src   = r_mac_src;
   assign bus.hp_mac_dst   = r_mac_dst;
   assign bus.hp_ip_src    = r_ip_src;
   assign bus.hp_ip_dst    = r_ip_dst;
   assign bus.hp_port_src  = r_port_src;
   assign bus.hp_port_dst  = r_port_dst;
   assign bus.hp_res_valid = (r_state == StResult);
   assign bus.hp_res_id    = r_res_id;
   assign bus.hp_res_error = r_res_error;
   assign bus.hp_res_del   = r_res_del;
   assign bus.hp_drop_cnt  = r_drop;

endmodule

// File: tb/tb_tcp_hdr_parser.sv
module tb_tcp_hdr_parser;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tcp_hdr_parser_if u_if ();

   tcp_hdr_parser #(
      .SETUP_CYC   (2),
      .TIMEOUT_CYC (255)
   ) u_dut (
      .hp_clk (clk),
      .hp_rst (rst),
      .bus    (u_if)
   );

   typedef struct packed {
      logic [7:0] id;
      logic [7:0] err;
      logic       del;
   } res_t;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         rq_cnt  = 0;
   res_t       exp_q[$];
   logic [7:0] frm[$];

   logic [7:0]  dmac [6] = '{8'h02, 8'h00, 8'h00, 8'hA1, 8'hB2, 8'hC3};
   logic [7:0]  smac [6] = '{8'h02, 8'h00, 8'h00, 8'hD4, 8'hE5, 8'hF6};
   logic [31:0] ip_src   = 32'hC0A8010A;
   logic [31:0] ip_dst   = 32'hC0A80114;

   always @(posedge clk) if (u_if.hp_rq != 2'b00) rq_cnt <= rq_cnt + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Builds one frame; len==0 means a full 20-byte TCP header after the IP options.
   task automatic build(input logic [15:0] etype, input logic [7:0] proto, input logic [3:0] ihl,
                        input logic [15:0] sport, input logic [15:0] dport,
                        input logic [7:0] flags, input int len);
      int         t;
      logic [7:0] b;
      t = 14 + 4 * int'(ihl);
      if (len == 0) len = t + 20;
      frm.delete();
      for (int i = 0; i < len; i++) begin
         b = 8'h00;
         if (i < 6)                   b = dmac[i];
         else if (i < 12)             b = smac[i - 6];
         else if (i == 12)            b = etype[15:8];
         else if (i == 13)            b = etype[7:0];
         else if (i == 14)            b = {4'h4, ihl};
         else if (i == 23)            b = proto;
         else if (i >= 26 && i < 30)  b = ip_src[(29 - i) * 8 +: 8];
         else if (i >= 30 && i < 34)  b = ip_dst[(33 - i) * 8 +: 8];
         else if (i >= 34 && i < t)   b = 8'hEE;
         else if (i == t)             b = sport[15:8];
         else if (i == t + 1)         b = sport[7:0];
         else if (i == t + 2)         b = dport[15:8];
         else if (i == t + 3)         b = dport[7:0];
         else if (i == t + 13)        b = flags;
         frm.push_back(b);
      end
   endtask

   task automatic send();
      for (int i = 0; i < frm.size(); i++) begin
         u_if.hp_in_data  = frm[i];
         u_if.hp_in_valid = 1'b1;
         u_if.hp_in_sof   = (i == 0);
         u_if.hp_in_eof   = (i == frm.size() - 1);
         tick();
      end
      u_if.hp_in_valid = 1'b0;
      u_if.hp_in_sof   = 1'b0;
      u_if.hp_in_eof   = 1'b0;
   endtask

   task automatic wait_rq(input logic [1:0] want, input string tag);
      int n = 0;
      while (u_if.hp_rq !== want && n < 600) begin
         tick();
         n++;
      end
      check(tag, 32'(u_if.hp_rq), 32'(want));
   endtask

   task automatic get_result(input string tag);
      int   n = 0;
      res_t e;
      while (u_if.hp_res_valid !== 1'b1 && n < 600) begin
         tick();
         n++;
      end
      check({tag, "_valid"}, 32'(u_if.hp_res_valid), 32'd1);
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_id"},  32'(u_if.hp_res_id),    32'(e.id));
         check({tag, "_err"}, 32'(u_if.hp_res_error), 32'(e.err));
         check({tag, "_del"}, 32'(u_if.hp_res_del),   32'(e.del));
      end
      u_if.hp_res_ready = 1'b1;
      tick();
      u_if.hp_res_ready = 1'b0;
   endtask

   initial begin
      int snap;
      int n;
      rst               = 1'b1;
      u_if.hp_in_data   = 8'h00;
      u_if.hp_in_valid  = 1'b0;
      u_if.hp_in_sof    = 1'b0;
      u_if.hp_in_eof    = 1'b0;
      u_if.hp_rs_done   = 1'b0;
      u_if.hp_rs_error  = 8'h00;
      u_if.hp_rs_id     = 8'h00;
      u_if.hp_res_ready = 1'b0;
      repeat (3) tick();
      check("rst_rq",    32'(u_if.hp_rq),        32'd0);
      check("rst_ready", 32'(u_if.hp_in_ready),  32'd1);
      check("rst_valid", 32'(u_if.hp_res_valid), 32'd0);
      check("rst_drop",  32'(u_if.hp_drop_cnt),  32'd0);
      check("rst_ipsrc", u_if.hp_ip_src,         32'd0);
      rst = 1'b0;
      tick();

      // SYN lookup, new connection; exact setup timing and result hold.
      exp_q.push_back('{id: 8'h05, err: 8'h02, del: 1'b0});
      build(16'h0800, 8'd6, 4'd5, 16'h1234, 16'h0050, 8'h02, 0);
      send();
      check("t1_setup0",  32'(u_if.hp_rq),       32'd0);
      check("t1_ready0",  32'(u_if.hp_in_ready), 32'd0);
      check("t1_macdst",  32'(u_if.hp_mac_dst),  32'hA1B2C3);
      check("t1_macsrc",  32'(u_if.hp_mac_src),  32'hD4E5F6);
      check("t1_ipsrc",   u_if.hp_ip_src,        32'hC0A8010A);
      check("t1_ipdst",   u_if.hp_ip_dst,        32'hC0A80114);
      check("t1_psrc",    32'(u_if.hp_port_src), 32'h1234);
      check("t1_pdst",    32'(u_if.hp_port_dst), 32'h0050);
      tick();
      check("t1_setup1",  32'(u_if.hp_rq),       32'd0);
      tick();
      check("t1_req",     32'(u_if.hp_rq),       32'd1);
      u_if.hp_rs_id    = 8'h05;
      u_if.hp_rs_error = 8'h02;
      u_if.hp_rs_done  = 1'b1;
      tick();
      check("t1_rq_off",  32'(u_if.hp_rq),       32'd0);
      for (int i = 0; i < 10; i++) begin
         check("t1_hold_valid", 32'(u_if.hp_res_valid), 32'd1);
         check("t1_hold_id",    32'(u_if.hp_res_id),    32'h05);
         tick();
      end
      get_result("t1");
      u_if.hp_rs_done = 1'b0;
      tick();

      // FIN hitting an existing connection triggers a delete.
      exp_q.push_back('{id: 8'h03, err: 8'h01, del: 1'b1});
      build(16'h0800, 8'd6, 4'd5, 16'h2222, 16'h0050, 8'h11, 0);
      send();
      wait_rq(2'b01, "t2_req");
      u_if.hp_rs_id    = 8'h03;
      u_if.hp_rs_error = 8'h01;
      u_if.hp_rs_done  = 1'b1;
      tick();
      check("t2_dsetup0", 32'(u_if.hp_rq),     32'd0);
      check("t2_idout",   32'(u_if.hp_id_out), 32'h03);
      tick();
      check("t2_dsetup1", 32'(u_if.hp_rq),     32'd0);
      tick();
      check("t2_dreq",    32'(u_if.hp_rq),     32'd2);
      repeat (3) tick();
      check("t2_dreq_wait", 32'(u_if.hp_rq),   32'd2);
      u_if.hp_rs_done = 1'b0;
      tick();
      u_if.hp_rs_done = 1'b1;
      tick();
      check("t2_rq_off",  32'(u_if.hp_rq),     32'd0);
      get_result("t2");
      u_if.hp_rs_done = 1'b0;
      tick();

      // Non-IPv4 and non-TCP frames are dropped without a request.
      snap = rq_cnt;
      build(16'h86DD, 8'd6, 4'd5, 16'h1111, 16'h0050, 8'h02, 0);
      send();
      build(16'h0800, 8'd17, 4'd5, 16'h1111, 16'h0050, 8'h02, 0);
      send();
      repeat (4) tick();
      check("t3_no_rq", 32'(rq_cnt - snap),     32'd0);
      check("t3_drop",  32'(u_if.hp_drop_cnt),  32'd2);

      // IHL=7 moves the TCP header; then a truncated IHL=7 frame is dropped.
      exp_q.push_back('{id: 8'h07, err: 8'h02, del: 1'b0});
      build(16'h0800, 8'd6, 4'd7, 16'hABCD, 16'h01BB, 8'h02, 0);
      send();
      check("t4_psrc", 32'(u_if.hp_port_src), 32'hABCD);
      check("t4_pdst", 32'(u_if.hp_port_dst), 32'h01BB);
      wait_rq(2'b01, "t4_req");
      u_if.hp_rs_id    = 8'h07;
      u_if.hp_rs_error = 8'h02;
      u_if.hp_rs_done  = 1'b1;
      tick();
      u_if.hp_rs_done = 1'b0;
      get_result("t4");
      build(16'h0800, 8'd6, 4'd7, 16'h5555, 16'h6666, 8'h02, 41);
      send();
      tick();
      check("t4_trunc_drop",  32'(u_if.hp_drop_cnt), 32'd3);
      check("t4_trunc_ready", 32'(u_if.hp_in_ready), 32'd1);
      check("t4_trunc_rq",    32'(u_if.hp_rq),       32'd0);

      // Searcher never answers.
      exp_q.push_back('{id: 8'h00, err: 8'hFF, del: 1'b0});
      build(16'h0800, 8'd6, 4'd5, 16'h3333, 16'h0050, 8'h02, 0);
      send();
      wait_rq(2'b01, "t5_req");
      n = 0;
      while (u_if.hp_rq === 2'b01 && n < 400) begin
         tick();
         n++;
      end
      check("t5_timeout_cycles", 32'(n), 32'd255);
      check("t5_rq_off", 32'(u_if.hp_rq), 32'd0);
      get_result("t5");

      // Reset while a lookup is outstanding.
      build(16'h0800, 8'd6, 4'd5, 16'h4444, 16'h0050, 8'h02, 0);
      send();
      wait_rq(2'b01, "t6_req");
      rst = 1'b1;
      tick();
      check("t6_rq",    32'(u_if.hp_rq),        32'd0);
      check("t6_ready", 32'(u_if.hp_in_ready),  32'd1);
      check("t6_valid", 32'(u_if.hp_res_valid), 32'd0);
      check("t6_drop",  32'(u_if.hp_drop_cnt),  32'd0);
      rst = 1'b0;
      tick();
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
